// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg - configurable UART transmitter.
//
// Serialises one word per frame, LSB first: start bit, 1..MAX_WORD_SIZE data
// bits, optional even/odd parity, then one or two stop bits. Every bit lasts
// baud_div+1 clk cycles. All frame settings are captured when a frame is
// accepted, so the inputs may change freely while a frame is on the line.
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   din          data word (LSB sent first)
//   tx_bits      data bits per frame (0 -> 1, >MAX_WORD_SIZE -> MAX_WORD_SIZE)
//   parity_mode  0/3 = none, 1 = even, 2 = odd
//   stop2        0 = one stop bit, 1 = two stop bits
//   baud_div     bit period minus one, in clk cycles
//   tx_start     frame request, taken only while tx_ready=1
//   tx_ready     a new frame can be accepted
//   tx_done      one-cycle pulse when the last stop bit ends
//   tx           registered serial output, idle high
module uart_tx_cfg #(
  parameter int unsigned MAX_WORD_SIZE = 8,
  parameter int unsigned DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_WORD_SIZE-1:0] din,
  input  logic [5:0]               tx_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     stop2,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic                     tx_start,
  output logic                     tx_ready,
  output logic                     tx_done,
  output logic                     tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [5:0] MAX_BITS = 6'(MAX_WORD_SIZE);

  state_t                   state, state_n;
  logic [DIV_W-1:0]         baud_cnt, baud_cnt_n;
  logic [5:0]               bit_idx, bit_idx_n;
  logic                     stop_cnt, stop_cnt_n;

  // Frame settings captured at acceptance.
  logic [MAX_WORD_SIZE-1:0] sh_din, sh_din_n;
  logic [5:0]               sh_bits, sh_bits_n;
  logic [DIV_W-1:0]         sh_div, sh_div_n;
  logic                     sh_par_en, sh_par_en_n;
  logic                     sh_par_bit, sh_par_bit_n;
  logic                     sh_stop2, sh_stop2_n;

  logic                     tx_n, ready_n, done_n;

  logic [5:0]               bits_clamped;
  logic [MAX_WORD_SIZE-1:0] data_mask;
  logic                     par_calc;
  logic [MAX_WORD_SIZE-1:0] din_shr;
  logic                     bit_end;

  always_comb begin
    if (tx_bits == '0) begin
      bits_clamped = 6'd1;
    end else if (tx_bits > MAX_BITS) begin
      bits_clamped = MAX_BITS;
    end else begin
      bits_clamped = tx_bits;
    end
  end

  // Parity is resolved once at acceptance over only the bits actually sent;
  // shifting in a full-width mask leaves ones in exactly [bits-1:0].
  assign data_mask = ~({MAX_WORD_SIZE{1'b1}} << bits_clamped);
  assign par_calc  = ^(din & data_mask);

  // The shadow word is shifted right as bits go out, so the next data bit is
  // always bit 1 of the current shadow value.
  assign din_shr = sh_din >> 1;
  assign bit_end = (baud_cnt == sh_div);

  always_comb begin
    state_n      = state;
    baud_cnt_n   = '0;
    bit_idx_n    = bit_idx;
    stop_cnt_n   = stop_cnt;
    sh_din_n     = sh_din;
    sh_bits_n    = sh_bits;
    sh_div_n     = sh_div;
    sh_par_en_n  = sh_par_en;
    sh_par_bit_n = sh_par_bit;
    sh_stop2_n   = sh_stop2;
    tx_n         = tx;
    ready_n      = tx_ready;
    done_n       = 1'b0;

    if (state != IDLE && !bit_end) begin
      baud_cnt_n = baud_cnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        if (tx_start) begin
          sh_din_n     = din;
          sh_bits_n    = bits_clamped;
          sh_div_n     = baud_div;
          sh_par_en_n  = parity_mode[0] ^ parity_mode[1];
          sh_par_bit_n = par_calc ^ (parity_mode == 2'd2);
          sh_stop2_n   = stop2;
          bit_idx_n    = '0;
          stop_cnt_n   = 1'b0;
          tx_n         = 1'b0;
          ready_n      = 1'b0;
          state_n      = START;
        end
      end

      START: begin
        if (bit_end) begin
          bit_idx_n = '0;
          tx_n      = sh_din[0];
          state_n   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx == sh_bits - 6'd1) begin
            if (sh_par_en) begin
              tx_n    = sh_par_bit;
              state_n = PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end else begin
            bit_idx_n = bit_idx + 6'd1;
            sh_din_n  = din_shr;
            tx_n      = din_shr[0];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (sh_stop2 && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else begin
            stop_cnt_n = 1'b0;
            tx_n       = 1'b1;
            ready_n    = 1'b1;
            done_n     = 1'b1;
            state_n    = IDLE;
          end
        end
      end

      default: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      sh_din     <= '0;
      sh_bits    <= '0;
      sh_div     <= '0;
      sh_par_en  <= 1'b0;
      sh_par_bit <= 1'b0;
      sh_stop2   <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      stop_cnt   <= stop_cnt_n;
      sh_din     <= sh_din_n;
      sh_bits    <= sh_bits_n;
      sh_div     <= sh_div_n;
      sh_par_en  <= sh_par_en_n;
      sh_par_bit <= sh_par_bit_n;
      sh_stop2   <= sh_stop2_n;
      tx         <= tx_n;
      tx_ready   <= ready_n;
      tx_done    <= done_n;
    end
  end

endmodule
